// File: rtl/pp_block_buffer_if.sv
// Handshake bundle for pp_block_buffer: write stream in, read stream out, bank status.
// The buffer connects through the slave modport; the producer/consumer side uses master.
interface pp_block_buffer_if #(
   parameter int DATA_W = 1
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_sob;
   logic              out_eob;
   logic [1:0]        bank_full;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sob, out_eob, bank_full
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sob, out_eob, bank_full
   );
endinterface

// File: rtl/pp_block_buffer.sv
// Ping-pong block buffer: one bank fills while the other drains, valid/ready on both sides.
// Optional early block close via `define PPBUF_FLUSH_EN (adds the flush port and per-bank lengths).
module pp_block_buffer #(
   parameter int DATA_W    = 1,
   parameter int BLOCK_LEN = 192,
   localparam int CNT_W    = $clog2(BLOCK_LEN)
) (
   input  logic            clk,
   input  logic            resetN,
`ifdef PPBUF_FLUSH_EN
   input  logic            flush,
`endif
   pp_block_buffer_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [1:0]        full_q, full_d;
   logic [DATA_W-1:0] mem_q [2][BLOCK_LEN];

   logic              wr_fire;
   logic              rd_fire;
   logic              wr_close;
   logic              rd_end;
   logic [CNT_W-1:0]  rd_last;

`ifdef PPBUF_FLUSH_EN
   logic [CNT_W:0]    len_q [2];
   logic [CNT_W:0]    len_d [2];
   logic [CNT_W:0]    close_len;
`endif

   always_comb begin
      wr_fire = bus.in_valid && !full_q[wr_bank_q];
      rd_fire = full_q[rd_bank_q] && bus.out_ready;
`ifdef PPBUF_FLUSH_EN
      // A natural end-of-block write wins over flush, so the block is always BLOCK_LEN then.
      if (wr_fire && wr_cnt_q == LAST_IDX)
         close_len = (CNT_W+1)'(BLOCK_LEN);
      else
         close_len = {1'b0, wr_cnt_q} + {{CNT_W{1'b0}}, wr_fire};
      wr_close = (wr_fire && wr_cnt_q == LAST_IDX) || (flush && close_len != '0);
      rd_last  = CNT_W'(len_q[rd_bank_q] - (CNT_W+1)'(1));
`else
      wr_close = wr_fire && wr_cnt_q == LAST_IDX;
      rd_last  = LAST_IDX;
`endif
      rd_end    = rd_fire && rd_cnt_q == rd_last;

      wr_bank_d = wr_bank_q ^ wr_close;
      wr_cnt_d  = wr_close ? '0 : wr_cnt_q + CNT_W'(wr_fire);
      rd_bank_d = rd_bank_q ^ rd_end;
      rd_cnt_d  = rd_end ? '0 : rd_cnt_q + CNT_W'(rd_fire);

      // Write closes a non-full bank and read ends a full one, so they never collide.
      full_d = full_q;
      if (wr_close) full_d[wr_bank_q] = 1'b1;
      if (rd_end)   full_d[rd_bank_q] = 1'b0;
`ifdef PPBUF_FLUSH_EN
      len_d = len_q;
      if (wr_close) len_d[wr_bank_q] = close_len;
`endif
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         full_q    <= 2'b00;
`ifdef PPBUF_FLUSH_EN
         len_q[0]  <= '0;
         len_q[1]  <= '0;
`endif
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         full_q    <= full_d;
`ifdef PPBUF_FLUSH_EN
         len_q     <= len_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_bank_q][wr_cnt_q] <= bus.in_data;
   end

   assign bus.in_ready  = !full_q[wr_bank_q];
   assign bus.out_valid = full_q[rd_bank_q];
   assign bus.out_data  = full_q[rd_bank_q] ? mem_q[rd_bank_q][rd_cnt_q] : '0;
   assign bus.out_sob   = full_q[rd_bank_q] && rd_cnt_q == '0;
   assign bus.out_eob   = full_q[rd_bank_q] && rd_cnt_q == rd_last;
   assign bus.bank_full = full_q;

endmodule

// File: tb/tb_pp_block_buffer.sv
// Bench for pp_block_buffer: three instances (4x8b, 192x1b, 5x8b) checked every cycle
// against a queue-based block model, plus literal checks for the directed scenarios.
module tb_pp_block_buffer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]       in_valid_a  = '0;
   logic [2:0][7:0]  in_data_a   = '0;
   logic [2:0]       out_ready_a = '0;
   logic [2:0]       in_ready_a;
   logic [2:0]       out_valid_a;
   logic [2:0][7:0]  out_data_a;
   logic [2:0]       out_sob_a;
   logic [2:0]       out_eob_a;
   logic [2:0][1:0]  bank_full_a;
`ifdef PPBUF_FLUSH_EN
   logic [2:0]       flush_a = '0;
`endif

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int DW = (g == 1) ? 1 : 8;
      localparam int BL = (g == 0) ? 4 : (g == 1) ? 192 : 5;
      localparam logic [7:0] MSK = (DW == 8) ? 8'hFF : 8'h01;

      pp_block_buffer_if #(.DATA_W(DW)) bus ();

      pp_block_buffer #(.DATA_W(DW), .BLOCK_LEN(BL)) dut (
         .clk    (clk),
         .resetN (rst_n),
`ifdef PPBUF_FLUSH_EN
         .flush  (flush_a[g]),
`endif
         .bus    (bus)
      );

      assign bus.in_valid     = in_valid_a[g];
      assign bus.in_data      = in_data_a[g][DW-1:0];
      assign bus.out_ready    = out_ready_a[g];
      assign in_ready_a[g]    = bus.in_ready;
      assign out_valid_a[g]   = bus.out_valid;
      assign out_data_a[g]    = 8'(bus.out_data);
      assign out_sob_a[g]     = bus.out_sob;
      assign out_eob_a[g]     = bus.out_eob;
      assign bank_full_a[g]   = bus.bank_full;

      // Model: closed blocks waiting to be read (words + lengths), plus the block being filled.
      logic [7:0] dq[$];
      int         lq[$];
      logic [7:0] part[$];
      int         rd_idx;
      int         rd_par;

      always @(posedge clk or negedge rst_n) begin : model
         int nf;
         bit wr, rd;
         if (!rst_n) begin
            dq.delete(); lq.delete(); part.delete();
            rd_idx = 0; rd_par = 0;
         end else begin
            nf = lq.size();
            wr = in_valid_a[g] && nf < 2;
            rd = out_ready_a[g] && nf > 0;
            if (rd) begin
               void'(dq.pop_front());
               rd_idx++;
               if (rd_idx == lq[0]) begin
                  void'(lq.pop_front());
                  rd_idx = 0;
                  rd_par ^= 1;
               end
            end
            if (wr) begin
               part.push_back(in_data_a[g] & MSK);
               if (part.size() == BL) begin
                  foreach (part[k]) dq.push_back(part[k]);
                  lq.push_back(BL);
                  part.delete();
               end
            end
`ifdef PPBUF_FLUSH_EN
            if (flush_a[g] && part.size() > 0) begin
               foreach (part[k]) dq.push_back(part[k]);
               lq.push_back(part.size());
               part.delete();
            end
`endif
         end
      end

      always @(negedge clk) begin : compare
         int nf;
         logic ev;
         logic [7:0] ed;
         logic [1:0] bf;
         nf = lq.size();
         ev = nf > 0;
         ed = ev ? dq[0] : 8'h00;
         bf = 2'b00;
         for (int k = 0; k < nf; k++) bf[(rd_par + k) % 2] = 1'b1;
         chk($sformatf("g%0d_in_ready", g),  32'(in_ready_a[g]),  32'(nf < 2));
         chk($sformatf("g%0d_out_valid", g), 32'(out_valid_a[g]), 32'(ev));
         chk($sformatf("g%0d_out_data", g),  32'(out_data_a[g]),  32'(ed));
         chk($sformatf("g%0d_out_sob", g),   32'(out_sob_a[g]),   32'(ev && rd_idx == 0));
         chk($sformatf("g%0d_out_eob", g),   32'(out_eob_a[g]),   32'(ev && rd_idx == lq[0] - 1));
         chk($sformatf("g%0d_bank_full", g), 32'(bank_full_a[g]), 32'(bf));
      end
   end

   initial begin
      int acc, n, first, nval, nsob, reads, neob, cyc;

      // Reset state and idle after release
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  32'(in_ready_a),  32'h7);
      chk("rst_out_valid", 32'(out_valid_a), 32'h0);
      chk("rst_bank_full", 32'(bank_full_a), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_out_valid", 32'(out_valid_a), 32'h0);
      chk("idle_in_ready",  32'(in_ready_a),  32'h7);

      // Single block on the 4x8 instance
      out_ready_a[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid_a[0] = 1'b1;
         in_data_a[0]  = 8'(8'h11 + i);
         @(negedge clk);
      end
      in_valid_a[0] = 1'b0;
      chk("blk_first_data", 32'(out_data_a[0]), 32'h11);
      chk("blk_first_sob",  32'(out_sob_a[0]),  32'h1);
      @(negedge clk); chk("blk_d1", 32'(out_data_a[0]), 32'h12);
      @(negedge clk); chk("blk_d2", 32'(out_data_a[0]), 32'h13);
      @(negedge clk);
      chk("blk_d3",  32'(out_data_a[0]), 32'h14);
      chk("blk_eob", 32'(out_eob_a[0]),  32'h1);
      @(negedge clk);
      chk("blk_empty", 32'(bank_full_a[0]), 32'h0);

      // Back-pressure: both banks fill, then free one
      out_ready_a[0] = 1'b0;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         in_valid_a[0] = 1'b1;
         in_data_a[0]  = 8'($urandom);
         if (in_ready_a[0]) acc++;
         @(negedge clk);
      end
      in_valid_a[0] = 1'b0;
      chk("bp_accepted",  32'(acc), 32'd8);
      chk("bp_in_ready",  32'(in_ready_a[0]), 32'h0);
      chk("bp_bank_full", 32'(bank_full_a[0]), 32'h3);
      out_ready_a[0] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("bp_ready_after_read%0d", k), 32'(in_ready_a[0]), 32'(k == 4));
      end
      repeat (6) @(negedge clk);

      // Streaming 10 blocks of 192 bits
      out_ready_a[1] = 1'b1;
      first = -1; nval = 0; nsob = 0;
      for (n = 0; n < 2120; n++) begin
         if (out_valid_a[1]) begin
            nval++;
            if (first < 0) first = n;
         end
         if (out_valid_a[1] && out_sob_a[1]) nsob++;
         in_valid_a[1] = (n < 1920);
         in_data_a[1]  = 8'($urandom_range(0, 1));
         @(negedge clk);
      end
      in_valid_a[1] = 1'b0;
      chk("stream_first_valid", 32'(first), 32'd192);
      chk("stream_valid_cycles", 32'(nval), 32'd1920);
      chk("stream_sob_count", 32'(nsob), 32'd10);

      // Random valid/ready on the 5-word instance
      acc = 0; reads = 0; nsob = 0; neob = 0; cyc = 0;
      while (reads < 1000 && cyc < 8000) begin
         in_valid_a[2]  = (acc < 1000) && ($urandom_range(0, 9) < 7);
         in_data_a[2]   = 8'($urandom);
         out_ready_a[2] = ($urandom_range(0, 9) < 6);
         if (in_valid_a[2] && in_ready_a[2]) acc++;
         if (out_valid_a[2] && out_ready_a[2]) begin
            reads++;
            if (out_sob_a[2]) nsob++;
            if (out_eob_a[2]) neob++;
         end
         cyc++;
         @(negedge clk);
      end
      in_valid_a[2] = 1'b0;
      out_ready_a[2] = 1'b0;
      chk("rand_in_budget", 32'(cyc < 8000), 32'h1);
      chk("rand_reads", 32'(reads), 32'd1000);
      chk("rand_sob",   32'(nsob),  32'd200);
      chk("rand_eob",   32'(neob),  32'd200);

      // Reset in the middle of a block
      out_ready_a[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid_a[0] = 1'b1;
         in_data_a[0]  = 8'(8'h50 + i);
         @(negedge clk);
      end
      in_valid_a[0] = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      #2;
      chk("midrst_bank_full", 32'(bank_full_a[0]), 32'h0);
      chk("midrst_out_valid", 32'(out_valid_a[0]), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      out_ready_a[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_no_output", 32'(out_valid_a[0]), 32'h0);

`ifdef PPBUF_FLUSH_EN
      in_valid_a[0] = 1'b1; in_data_a[0] = 8'hA0;
      @(negedge clk);
      in_data_a[0] = 8'hA1;
      @(negedge clk);
      in_valid_a[0] = 1'b0; flush_a[0] = 1'b1;
      @(negedge clk);
      flush_a[0] = 1'b0;
      chk("flush_d0",  32'(out_data_a[0]), 32'hA0);
      chk("flush_sob", 32'(out_sob_a[0]),  32'h1);
      @(negedge clk);
      chk("flush_d1",  32'(out_data_a[0]), 32'hA1);
      chk("flush_eob", 32'(out_eob_a[0]),  32'h1);
      repeat (3) @(negedge clk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pp_block_buffer.md
Name: pp_block_buffer

Overview:
Parametrised ping-pong block buffer for the WiMAX bit/symbol datapath, e.g. between the randomizer/FEC encoder and the interleaver.
- Contains two internal banks of BLOCK_LEN words. The write side fills one bank while the read side drains the other.
- Both sides use a valid/ready handshake, so the block supports back-pressure and continuous 1-word/cycle streaming.
- It generalises the fixed 192-bit, 1-bit-wide, external-RAM controller: configurable width and depth, internal storage, and block start/end markers.

Parameters:
DATA_W, 1, width of each stored word in bits
BLOCK_LEN, 192, words per block (per bank); must be >= 2
CNT_W, $clog2(BLOCK_LEN), width of the address counters (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
resetN  in  1  reset, asynchronous assert, active-low
in_valid  in  1  write data valid
in_ready  out  1  buffer can accept a write this cycle
in_data  in  DATA_W  write word
out_valid  out  1  read word valid
out_ready  in  1  downstream accepts the read word
out_data  out  DATA_W  read word
out_sob  out  1  out_data is word 0 of a block (qualified by out_valid)
out_eob  out  1  out_data is the last word of a block (qualified by out_valid)
bank_full  out  2  per-bank full flag, for status/debug

Behaviour:
- The clock and reset are fixed as above: one clock `clk`; reset `resetN` is asynchronous and active-low.
- State registers:
  - wr_bank (1b) and wr_cnt (CNT_W) for the write side.
  - rd_bank (1b) and rd_cnt (CNT_W) for the read side.
  - full[1:0], driven out on bank_full.
- Reset values:
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full=2'b00.
  - Outputs: in_ready=1, out_valid=0, out_sob=0, out_eob=0, bank_full=0, out_data=0.
  - Memory contents are not reset.
- Write side:
  - in_ready = !full[wr_bank].
  - A write occurs when in_valid && in_ready; it stores in_data to mem[wr_bank][wr_cnt].
  - If the write hits wr_cnt == BLOCK_LEN-1: full[wr_bank] is set, wr_bank toggles and wr_cnt wraps to 0. Otherwise wr_cnt increments.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = mem[rd_bank][rd_cnt], driven combinationally from the registered array. Hold out_data at 0 when out_valid=0.
  - out_sob = out_valid && rd_cnt == 0.
  - out_eob = out_valid && rd_cnt == last index (BLOCK_LEN-1, or the flushed length minus 1).
  - A read occurs when out_valid && out_ready; rd_cnt increments.
  - On the last word: full[rd_bank] clears, rd_bank toggles and rd_cnt wraps to 0.
- Latency:
  - The first word of a block appears on out_data with out_valid=1 in the cycle after the edge that wrote the block's last word.
  - With out_ready held at 1, a block of BLOCK_LEN writes yields BLOCK_LEN consecutive reads.
  - Continuous input with continuous out_ready gives sustained 1 word/cycle with no bubbles.
- Simultaneous events:
  - A write completing bank X and a read completing bank Y in the same cycle are independent.
  - X==Y is impossible: a write needs !full and a read needs full.
  - Both banks full: in_ready=0 until the read side frees a bank. in_ready rises the cycle after the last read of that bank (registered full flag; no same-cycle pass-through).
  - Both banks empty: out_valid=0; partial writes are not visible to the read side.
- Ordering: blocks are read strictly in write order; words within a block are read in write order.
- Reset mid-operation: all pointers and flags return to their reset values immediately (asynchronously); partially written or partially read blocks are discarded.

Optional Feature:
Macro PPBUF_FLUSH_EN.
- Defined:
  - Adds input port `flush` (1b) and a CNT_W+1-bit length register per bank.
  - When flush=1, the current write bank is closed early. Its length is wr_cnt, plus 1 if a write occurs in the same cycle.
  - Closing sets full, toggles wr_bank and clears wr_cnt.
  - A flush with resulting length 0 is ignored.
  - A flush coinciding with a natural end-of-block write behaves as a normal full block.
  - The read side uses the stored length for out_eob and wrap.
- Not defined:
  - No `flush` port and no length registers.
  - Every block is exactly BLOCK_LEN words.

Test Plan:
- Reset: assert resetN=0 -> in_ready=1, out_valid=0, bank_full=00; release with no traffic -> outputs unchanged for 10 cycles.
- Single block (DATA_W=8, BLOCK_LEN=4): write 0x11..0x14 with out_ready=1 -> cycle after the 4th write: out_data=0x11 with out_sob=1; next 3 cycles 0x12, 0x13, 0x14; out_eob=1 on 0x14; bank_full returns to 00.
- Back-pressure (BLOCK_LEN=4): out_ready=0, in_valid=1 continuously -> exactly 8 writes accepted, then in_ready=0 and bank_full=11; raise out_ready -> in_ready returns to 1 one cycle after the 4th read.
- Streaming (BLOCK_LEN=192, DATA_W=1): 10 blocks of a random bit stream, in_valid=1, out_ready=1 -> output equals input delayed 192 cycles with zero bubbles; out_sob every 192 cycles.
- Random valid/ready (BLOCK_LEN=5): 1000 random words with random in_valid and out_ready stalls -> output sequence identical to input; sob/eob at words 0 and 4 of each block.
- Reset mid-block then flush (PPBUF_FLUSH_EN, BLOCK_LEN=4):
  - Write 2 words, pulse resetN low -> bank_full=00 and no output.
  - Write 0xA0, 0xA1, pulse flush -> outputs 0xA0 then 0xA1, with out_eob=1 on 0xA1.
